id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter FWD_EN, default 1: 1 enables operand forwarding, 0 disables it (operands taken only from registered ID values).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port id_valid  input  1  decode stage holds a valid instruction.
REQ-005 SHALL have ports id_rs_data, id_rt_data  input  32 each  register-file read data.
REQ-006 SHALL have ports id_rs, id_rt, id_rd  input  5 each  register specifiers.
REQ-007 SHALL have ports id_imm  input  32  sign-extended immediate; id_shamt  input  5  shift amount.
REQ-008 SHALL have ports id_alu_control  input  4  ALU op code; id_alu_src  input  1  1 selects immediate for operand B; id_reg_dst  input  1  1 selects rd, 0 selects rt as destination.
REQ-009 SHALL have ports id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  input  1 each  decoded controls.
REQ-010 SHALL have ports exmem_reg_write  input  1, exmem_rd  input  5, exmem_result  input  32  EX/MEM forwarding source.
REQ-011 SHALL have ports memwb_reg_write  input  1, memwb_rd  input  5, memwb_data  input  32  MEM/WB forwarding source.
REQ-012 SHALL have port flush  input  1  squash instruction entering EX (taken branch/jump).
REQ-013 SHALL have ports alu_a, alu_b  output  32 each; alu_control  output  4; shamt  output  5  ALU operands.
REQ-014 SHALL have ports ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  output  1 each; ex_write_reg  output  5; ex_store_data  output  32.
REQ-015 SHALL have port stall  output  1  load-use hazard; upstream holds PC and IF/ID.

Function
REQ-016 SHALL register all ID inputs into the EX stage in one cycle (latency 1) when not stalled and not flushed.
REQ-017 SHALL register ex_write_reg = id_reg_dst ? id_rd : id_rt at capture.
REQ-018 SHALL assert stall combinationally when id_valid & ex_valid & ex_mem_read & ex_write_reg != 0 & (ex_write_reg == id_rs | ex_write_reg == id_rt).
REQ-019 SHALL, on a stall cycle, load a bubble into EX: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg = 0; alu_control = 4'b0010 (ADD); operands/registers specifiers 0.
REQ-020 SHALL, on flush, load a bubble (as REQ-019); flush SHALL take priority over stall and over id_valid.
REQ-021 SHALL treat id_valid = 0 as a bubble capture.
REQ-022 SHALL select forwarded rs (fwd_a) combinationally from registered state: EX/MEM if exmem_reg_write & exmem_rd != 0 & exmem_rd == ex_rs; else MEM/WB if memwb_reg_write & memwb_rd != 0 & memwb_rd == ex_rs; else registered rs data.
REQ-023 SHALL select forwarded rt (fwd_b) by the same rule and priority (EX/MEM over MEM/WB) against ex_rt.
REQ-024 SHALL drive alu_a = fwd_a; alu_b = registered alu_src ? registered imm : fwd_b; ex_store_data = fwd_b.
REQ-025 SHALL never forward for register 0; with FWD_EN = 0 SHALL use registered data only.
REQ-026 SHALL drive alu_control and shamt directly from EX registers.
REQ-027 SHALL keep stall purely combinational; it SHALL deassert in the cycle after the bubble (load has left EX).

Reset
REQ-028 SHALL, on reset_n low, immediately clear all EX registers: all 1-bit outputs 0, ex_write_reg 0, alu_control 4'b0010, shamt 0, data registers 0; alu_a, alu_b, ex_store_data 0 (absent forwarding match); stall 0.
REQ-029 SHALL, on reset deassertion mid-operation, resume capture at the next rising edge with no residual instruction.

Verification
REQ-030 SHALL pass: ADD r3 = r1(5) + r2(7), no hazards -> next cycle alu_a = 5, alu_b = 7, alu_control = 0010, ex_write_reg = 3, ex_reg_write = 1.
REQ-031 SHALL pass: EX/MEM writes r1 = 100 and MEM/WB writes r1 = 200 while EX uses r1 -> alu_a = 100; remove EX/MEM match -> alu_a = 200; exmem_rd = 0 with matching rs = 0 -> no forward.
REQ-032 SHALL pass: LW r4 in EX, ID uses r4 as rt -> stall = 1 that cycle; next cycle ex_valid = 0, ex_mem_read = 0, stall = 0; instruction then captured with r4 forwarded from MEM/WB.
REQ-033 SHALL pass: flush = 1 together with a load-use stall and id_valid = 1 -> EX bubble next cycle, ex_reg_write = 0.
REQ-034 SHALL pass: id_alu_src = 1, imm = 0xFFFFFFFC, rt forwarded = 9 -> alu_b = 0xFFFFFFFC, ex_store_data = 9.
REQ-035 SHALL pass: reset_n pulsed low between clock edges with valid instruction in EX -> outputs reach REQ-028 values without a clock edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use stall
module id_ex_stage #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        id_valid,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_shamt,
    input  logic [3:0]  id_alu_control,
    input  logic        id_alu_src,
    input  logic        id_reg_dst,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        id_mem_to_reg,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_data,
    input  logic        flush,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_control,
    output logic [4:0]  shamt,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_mem_to_reg,
    output logic [4:0]  ex_write_reg,
    output logic [31:0] ex_store_data,
    output logic        stall
);

    localparam logic [3:0] ALU_ADD = 4'b0010;

    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [31:0] ex_imm;
    logic        ex_alu_src;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic        bubble;

    // A load in EX whose destination is read by the decoding instruction must wait one cycle
    assign stall = id_valid & ex_valid & ex_mem_read & (ex_write_reg != 5'd0)
                 & ((ex_write_reg == id_rs) | (ex_write_reg == id_rt));

    // Flush dominates stall, which dominates an otherwise valid capture
    assign bubble = flush | stall | ~id_valid;

    // EX stage register: capture decoded instruction or load a NOP-equivalent bubble
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_write_reg  <= 5'd0;
            ex_rs         <= 5'd0;
            ex_rt         <= 5'd0;
            ex_rs_data    <= 32'd0;
            ex_rt_data    <= 32'd0;
            ex_imm        <= 32'd0;
            ex_alu_src    <= 1'b0;
            alu_control   <= ALU_ADD;
            shamt         <= 5'd0;
        end else if (bubble) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_write_reg  <= 5'd0;
            ex_rs         <= 5'd0;
            ex_rt         <= 5'd0;
            ex_rs_data    <= 32'd0;
            ex_rt_data    <= 32'd0;
            ex_imm        <= 32'd0;
            ex_alu_src    <= 1'b0;
            alu_control   <= ALU_ADD;
            shamt         <= 5'd0;
        end else begin
            ex_valid      <= 1'b1;
            ex_reg_write  <= id_reg_write;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_write_reg  <= id_reg_dst ? id_rd : id_rt;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_rs_data    <= id_rs_data;
            ex_rt_data    <= id_rt_data;
            ex_imm        <= id_imm;
            ex_alu_src    <= id_alu_src;
            alu_control   <= id_alu_control;
            shamt         <= id_shamt;
        end
    end

    // Operand A: youngest producer (EX/MEM) wins over MEM/WB; r0 is never forwarded
    always_comb begin
        fwd_a = ex_rs_data;
        if (FWD_EN && exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == ex_rs)) begin
            fwd_a = exmem_result;
        end else if (FWD_EN && memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == ex_rs)) begin
            fwd_a = memwb_data;
        end
    end

    // Operand B / store data: same priority rule against rt
    always_comb begin
        fwd_b = ex_rt_data;
        if (FWD_EN && exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == ex_rt)) begin
            fwd_b = exmem_result;
        end else if (FWD_EN && memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == ex_rt)) begin
            fwd_b = memwb_data;
        end
    end

    assign alu_a         = fwd_a;
    assign alu_b         = ex_alu_src ? ex_imm : fwd_b;
    assign ex_store_data = fwd_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage (directed table plus random vs model)
module tb_id_ex_stage;

    typedef struct {
        logic        v;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd, imm;
        logic [4:0]  sh;
        logic [3:0]  ctl;
        logic        src, dst, rw, mr, mw, m2r;
        logic        xrw;
        logic [4:0]  xrd;
        logic [31:0] xres;
        logic        wrw;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        logic        flush;
    } vin_t;

    typedef struct {
        logic [31:0] a, b, sd;
        logic [3:0]  ctl;
        logic [4:0]  sh;
        logic [4:0]  wr;
        logic [4:0]  flg;
        logic        stall;
    } vexp_t;

    typedef struct {
        vin_t  i;
        vexp_t e;
    } vec_t;

    // Instruction currently sitting in EX, as the model sees it
    typedef struct {
        logic        valid, rw, mr, mw, m2r, src;
        logic [4:0]  wr, rs, rt, sh;
        logic [31:0] rsd, rtd, imm;
        logic [3:0]  ctl;
    } slot_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [3:0]  id_alu_control;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exmem_reg_write, memwb_reg_write, flush;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_data;

    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_control;
    logic [4:0]  shamt, ex_write_reg;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, stall;

    logic [31:0] n_alu_a, n_alu_b, n_store;
    logic [3:0]  n_alu_control;
    logic [4:0]  n_shamt, n_write_reg;
    logic        n_valid, n_reg_write, n_mem_read, n_mem_write, n_mem_to_reg, n_stall;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.FWD_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_imm(id_imm), .id_shamt(id_shamt), .id_alu_control(id_alu_control),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .flush(flush),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .shamt(shamt),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_write_reg(ex_write_reg), .ex_store_data(ex_store_data), .stall(stall)
    );

    id_ex_stage #(.FWD_EN(1'b0)) dut_nofwd (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_imm(id_imm), .id_shamt(id_shamt), .id_alu_control(id_alu_control),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .flush(flush),
        .alu_a(n_alu_a), .alu_b(n_alu_b), .alu_control(n_alu_control), .shamt(n_shamt),
        .ex_valid(n_valid), .ex_reg_write(n_reg_write), .ex_mem_read(n_mem_read),
        .ex_mem_write(n_mem_write), .ex_mem_to_reg(n_mem_to_reg),
        .ex_write_reg(n_write_reg), .ex_store_data(n_store), .stall(n_stall)
    );

    function automatic vin_t mk_in(int v, int rs, int rt, int rd, int rsd, int rtd, int imm,
                                   int ctl, int src, int dst, int c4, int xrw, int xrd, int xres,
                                   int wrw, int wrd, int wdat, int fl);
        vin_t r;
        r.v = 1'(v); r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd);
        r.rsd = rsd; r.rtd = rtd; r.imm = imm; r.sh = 5'd0; r.ctl = 4'(ctl);
        r.src = 1'(src); r.dst = 1'(dst);
        {r.rw, r.mr, r.mw, r.m2r} = 4'(c4);
        r.xrw = 1'(xrw); r.xrd = 5'(xrd); r.xres = xres;
        r.wrw = 1'(wrw); r.wrd = 5'(wrd); r.wdat = wdat;
        r.flush = 1'(fl);
        return r;
    endfunction

    function automatic vexp_t mk_exp(int a, int b, int sd, int ctl, int wr, int flg, int st);
        vexp_t r;
        r.a = a; r.b = b; r.sd = sd; r.ctl = 4'(ctl); r.sh = 5'd0;
        r.wr = 5'(wr); r.flg = 5'(flg); r.stall = 1'(st);
        return r;
    endfunction

    function automatic vin_t rnd_in();
        vin_t r;
        r.v = ($urandom_range(3) != 0);
        r.rs = 5'($urandom_range(7)); r.rt = 5'($urandom_range(7)); r.rd = 5'($urandom_range(7));
        r.rsd = $urandom; r.rtd = $urandom; r.imm = $urandom;
        r.sh = 5'($urandom_range(31)); r.ctl = 4'($urandom_range(15));
        r.src = 1'($urandom_range(1)); r.dst = 1'($urandom_range(1));
        r.rw = 1'($urandom_range(1)); r.mr = ($urandom_range(2) == 0);
        r.mw = 1'($urandom_range(1)); r.m2r = r.mr;
        r.xrw = 1'($urandom_range(1)); r.xrd = 5'($urandom_range(7)); r.xres = $urandom;
        r.wrw = 1'($urandom_range(1)); r.wrd = 5'($urandom_range(7)); r.wdat = $urandom;
        r.flush = ($urandom_range(7) == 0);
        return r;
    endfunction

    function automatic slot_t empty_slot();
        slot_t s;
        s.valid = 1'b0; s.rw = 1'b0; s.mr = 1'b0; s.mw = 1'b0; s.m2r = 1'b0; s.src = 1'b0;
        s.wr = 5'd0; s.rs = 5'd0; s.rt = 5'd0; s.sh = 5'd0;
        s.rsd = 32'd0; s.rtd = 32'd0; s.imm = 32'd0; s.ctl = 4'b0010;
        return s;
    endfunction

    // Value a source register should present: newest in-flight writer, r0 never bypassed
    function automatic logic [31:0] pick(logic [4:0] r, logic [31:0] d, vin_t i, bit en);
        if (!en || r == 5'd0) return d;
        if (i.xrw && i.xrd == r) return i.xres;
        if (i.wrw && i.wrd == r) return i.wdat;
        return d;
    endfunction

    function automatic vexp_t model_out(slot_t m, vin_t i, bit en);
        vexp_t e;
        logic [31:0] fb;
        fb = pick(m.rt, m.rtd, i, en);
        e.a = pick(m.rs, m.rsd, i, en);
        e.b = m.src ? m.imm : fb;
        e.sd = fb;
        e.ctl = m.ctl; e.sh = m.sh; e.wr = m.wr;
        e.flg = {m.valid, m.rw, m.mr, m.mw, m.m2r};
        e.stall = i.v && m.valid && m.mr && (m.wr != 5'd0) && (m.wr == i.rs || m.wr == i.rt);
        return e;
    endfunction

    function automatic slot_t next_slot(vin_t i, logic st);
        slot_t s;
        if (i.flush || st || !i.v) return empty_slot();
        s.valid = 1'b1; s.rw = i.rw; s.mr = i.mr; s.mw = i.mw; s.m2r = i.m2r; s.src = i.src;
        s.wr = i.dst ? i.rd : i.rt; s.rs = i.rs; s.rt = i.rt; s.sh = i.sh;
        s.rsd = i.rsd; s.rtd = i.rtd; s.imm = i.imm; s.ctl = i.ctl;
        return s;
    endfunction

    task automatic drive(input vin_t i);
        id_valid = i.v; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
        id_rs_data = i.rsd; id_rt_data = i.rtd; id_imm = i.imm; id_shamt = i.sh;
        id_alu_control = i.ctl; id_alu_src = i.src; id_reg_dst = i.dst;
        id_reg_write = i.rw; id_mem_read = i.mr; id_mem_write = i.mw; id_mem_to_reg = i.m2r;
        exmem_reg_write = i.xrw; exmem_rd = i.xrd; exmem_result = i.xres;
        memwb_reg_write = i.wrw; memwb_rd = i.wrd; memwb_data = i.wdat;
        flush = i.flush;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_main(input vexp_t e, input string tag, input bit with_sh);
        chk({tag, " alu_a"}, alu_a, e.a);
        chk({tag, " alu_b"}, alu_b, e.b);
        chk({tag, " store"}, ex_store_data, e.sd);
        chk({tag, " alu_control"}, 32'(alu_control), 32'(e.ctl));
        chk({tag, " write_reg"}, 32'(ex_write_reg), 32'(e.wr));
        chk({tag, " flags"}, 32'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}),
            32'(e.flg));
        chk({tag, " stall"}, 32'(stall), 32'(e.stall));
        if (with_sh) chk({tag, " shamt"}, 32'(shamt), 32'(e.sh));
    endtask

    initial begin
        vec_t  tab [13];
        slot_t m;
        vin_t  vi;
        vexp_t e, en;

        //                 v rs rt rd rsd    rtd      imm           ctl src dst c4     xrw xrd xres   wrw wrd wdat     fl
        tab[0].i  = mk_in(1, 1, 2, 3, 5,     7,       0,            2,  0,  1,  'b1000, 0, 0, 0,     0,  0,  0,       0);
        tab[0].e  = mk_exp(0, 0, 0, 2, 0, 'b00000, 0);
        tab[1].i  = mk_in(0, 0, 0, 0, 0,     0,       0,            2,  0,  0,  0,      0, 0, 0,     0,  0,  0,       0);
        tab[1].e  = mk_exp(5, 7, 7, 2, 3, 'b11000, 0);
        tab[2].i  = mk_in(1, 1, 2, 5, 1,     2,       0,            7,  0,  1,  'b1000, 0, 0, 0,     0,  0,  0,       0);
        tab[2].e  = mk_exp(0, 0, 0, 2, 0, 'b00000, 0);
        tab[3].i  = mk_in(1, 1, 2, 5, 1,     2,       0,            7,  0,  1,  'b1000, 1, 1, 100,   1,  1,  200,     0);
        tab[3].e  = mk_exp(100, 2, 2, 7, 5, 'b11000, 0);
        tab[4].i  = mk_in(1, 0, 2, 5, 'h11,  2,       0,            2,  0,  1,  'b1000, 1, 7, 100,   1,  1,  200,     0);
        tab[4].e  = mk_exp(200, 2, 2, 7, 5, 'b11000, 0);
        tab[5].i  = mk_in(1, 1, 4, 0, 50,    0,       8,            2,  1,  0,  'b1101, 1, 0, 100,   1,  0,  200,     0);
        tab[5].e  = mk_exp('h11, 2, 2, 2, 5, 'b11000, 0);
        tab[6].i  = mk_in(1, 1, 4, 6, 3,     'hDEAD,  0,            6,  0,  1,  'b1000, 0, 0, 0,     0,  0,  0,       0);
        tab[6].e  = mk_exp(50, 8, 0, 2, 4, 'b11101, 1);
        tab[7].i  = mk_in(1, 1, 4, 6, 3,     'hDEAD,  0,            6,  0,  1,  'b1000, 1, 4, 77,    0,  0,  0,       0);
        tab[7].e  = mk_exp(0, 0, 0, 2, 0, 'b00000, 0);
        tab[8].i  = mk_in(1, 1, 4, 0, 50,    0,       8,            2,  1,  0,  'b1101, 0, 0, 0,     1,  4,  'h1234,  0);
        tab[8].e  = mk_exp(3, 'h1234, 'h1234, 6, 6, 'b11000, 0);
        tab[9].i  = mk_in(1, 1, 4, 6, 3,     'hDEAD,  0,            6,  0,  1,  'b1000, 0, 0, 0,     0,  0,  0,       1);
        tab[9].e  = mk_exp(50, 8, 0, 2, 4, 'b11101, 1);
        tab[10].i = mk_in(1, 1, 2, 3, 5,     7,       0,            2,  0,  1,  'b1000, 0, 0, 0,     0,  0,  0,       1);
        tab[10].e = mk_exp(0, 0, 0, 2, 0, 'b00000, 0);
        tab[11].i = mk_in(1, 1, 9, 2, 1,     0,       32'hFFFFFFFC, 2,  1,  1,  'b1000, 0, 0, 0,     0,  0,  0,       0);
        tab[11].e = mk_exp(0, 0, 0, 2, 0, 'b00000, 0);
        tab[12].i = mk_in(0, 0, 0, 0, 0,     0,       0,            2,  0,  0,  0,      1, 9, 9,     0,  0,  0,       0);
        tab[12].e = mk_exp(1, 32'hFFFFFFFC, 9, 2, 2, 'b11000, 0);

        // Reset state
        reset_n = 1'b0;
        drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_main(mk_exp(0, 0, 0, 2, 0, 0, 0), "reset", 1'b1);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed scenarios
        for (int k = 0; k < 13; k++) begin
            drive(tab[k].i);
            @(negedge clk);
            check_main(tab[k].e, $sformatf("row%0d", k), 1'b0);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset between edges with a load-use pair in flight
        drive(mk_in(1, 1, 4, 0, 50, 0, 8, 2, 1, 0, 'b1101, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        drive(mk_in(1, 1, 4, 6, 3, 'hDEAD, 0, 6, 0, 1, 'b1000, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("pre_reset stall", 32'(stall), 32'd1);
        #1 reset_n = 1'b0;
        #1 check_main(mk_exp(0, 0, 0, 2, 0, 0, 0), "async_reset", 1'b1);
        drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic against the model, both forwarding variants
        m = empty_slot();
        for (int n = 0; n < 400; n++) begin
            vi = rnd_in();
            e  = model_out(m, vi, 1'b1);
            en = model_out(m, vi, 1'b0);
            drive(vi);
            @(negedge clk);
            check_main(e, $sformatf("rnd%0d", n), 1'b1);
            chk($sformatf("rnd%0d nofwd alu_a", n), n_alu_a, en.a);
            chk($sformatf("rnd%0d nofwd alu_b", n), n_alu_b, en.b);
            chk($sformatf("rnd%0d nofwd store", n), n_store, en.sd);
            @(posedge clk);
            m = next_slot(vi, e.stall);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
